// File: rtl/vx_mem_traffic_gen_pkg.sv
// Shared types and helpers for the memory traffic generator.
// Contents:
//   tg_state_e  - run-control FSM states
//   SLOT_IDX_W  - slot index width for the default 16-deep outstanding-read table
//   LINE_MAX_W  - widest memory line gen_line can produce
//   gen_line    - test pattern: 32-bit word j of line i = seed + i*words + j (mod 2**32)
package vx_traffic_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } tg_state_e;

    localparam int unsigned LINE_MAX_W = 1024;
    localparam int unsigned SLOT_IDX_W = 4;

    // Returns a LINE_MAX_W-bit line; callers cast it down to their line width
    // (which must not exceed LINE_MAX_W). Words at or above 'words' are zero.
    function automatic logic [LINE_MAX_W-1:0] gen_line(input logic [31:0] seed,
                                                       input logic [31:0] idx,
                                                       input int unsigned words);
        logic [LINE_MAX_W-1:0] line;
        line = '0;
        for (int unsigned j = 0; j < LINE_MAX_W / 32; j++) begin
            if (j < words) begin
                line[j*32 +: 32] = seed + idx * words + j;
            end
        end
        return line;
    endfunction

endpackage

// File: rtl/vx_mem_traffic_gen_if.sv
// Vortex-style memory request/response bus.
// Modports:
//   master - requester (drives mem_req_*, mem_rsp_ready; consumes mem_rsp_*)
//   slave  - memory side
interface vx_mem_traffic_gen_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned TAG_WIDTH  = 8
) ();

    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [DATA_WIDTH/8-1:0] mem_req_byteen;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_data;
    logic [TAG_WIDTH-1:0]    mem_req_tag;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH-1:0]    mem_rsp_tag;
    logic                    mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data,
        output mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data,
        input  mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );

endinterface

// File: rtl/vx_tag_slot_alloc.sv
// Outstanding-read slot allocator: free bitmap with lowest-free priority encoder.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset (all slots free)
//   alloc         - take slot alloc_idx this cycle
//   free/free_idx - release slot free_idx this cycle
//   alloc_idx     - lowest free slot index
//   free_map      - 1 = slot free (current state)
//   full          - no slot free
//   empty         - every slot free once this cycle's free has landed
module vx_tag_slot_alloc
    import vx_traffic_gen_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned SLOT_W    = SLOT_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc,
    input  logic                 free,
    input  logic [SLOT_W-1:0]    free_idx,
    output logic [SLOT_W-1:0]    alloc_idx,
    output logic [NUM_SLOTS-1:0] free_map,
    output logic                 full,
    output logic                 empty
);

    logic [NUM_SLOTS-1:0] free_q;
    logic [NUM_SLOTS-1:0] free_vec;
    logic [NUM_SLOTS-1:0] alloc_vec;

    always_comb begin
        alloc_idx = '0;
        // Walk downwards so the lowest free index wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_idx = SLOT_W'(i);
            end
        end
    end

    assign free_vec  = free  ? (NUM_SLOTS'(1) << free_idx)  : '0;
    assign alloc_vec = alloc ? (NUM_SLOTS'(1) << alloc_idx) : '0;
    assign free_map  = free_q;
    assign full      = ~|free_q;
    assign empty     = &(free_q | free_vec);

    // Free applies before allocate, so a slot can be released and reused together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_q <= '1;
        end else begin
            free_q <= (free_q | free_vec) & ~alloc_vec;
        end
    end

endmodule

// File: rtl/vx_mem_traffic_gen.sv
// Memory-subsystem self-test requester. Writes a seeded pattern to num_lines lines
// (base_addr + i*stride), reads them back with tagged reads that may complete out of
// order, checks each response and counts mismatches.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   start                   - pulse; begins a run when idle
//   base_addr, num_lines,
//   stride, seed            - run configuration, sampled at start
//   mem (master)            - Vortex memory request/response bus
//   busy, done              - run in progress / 1-cycle end-of-run pulse
//   err_count               - saturating data-mismatch count for this run
//   stray_rsp               - sticky: response whose tag was not outstanding
// Build option VX_TRAFFIC_GEN_PERF_EN adds perf_lat_sum / perf_lat_max (saturating
// read latency statistics, cleared at start).
module vx_mem_traffic_gen
    import vx_traffic_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ADDR_WIDTH      = 26,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_lines,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [31:0]           seed,
    vx_mem_traffic_gen_if.master  mem,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  stray_rsp
`ifdef VX_TRAFFIC_GEN_PERF_EN
    ,
    output logic [31:0]           perf_lat_sum,
    output logic [15:0]           perf_lat_max
`endif
);

    localparam int unsigned WORDS  = DATA_WIDTH / 32;
    localparam int unsigned SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    tg_state_e             state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [31:0]           seed_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rsp_ready_q;
    logic [CNT_WIDTH-1:0]  slot_line_q [MAX_OUTSTANDING];

    logic                       req_valid;
    logic                       req_fire;
    logic                       last_line;
    logic                       alloc;
    logic [SLOT_W-1:0]          alloc_idx;
    logic [MAX_OUTSTANDING-1:0] free_map;
    logic                       full;
    logic                       empty;
    logic [SLOT_W-1:0]          rsp_idx;
    logic                       rsp_fire;
    logic                       rsp_hit;
    logic                       rsp_stray;
    logic                       rsp_bad;
    logic [DATA_WIDTH-1:0]      wr_line;
    logic [DATA_WIDTH-1:0]      exp_line;

    // Request side is decoded from registered state only; no path from ready to valid.
    assign req_valid = (state == StWrite) || ((state == StRead) && !full);
    assign req_fire  = req_valid && mem.mem_req_ready;
    assign last_line = (idx_q == num_q - CNT_WIDTH'(1));
    assign alloc     = req_fire && (state == StRead);
    assign wr_line   = DATA_WIDTH'(gen_line(seed_q, 32'(idx_q), WORDS));

    assign mem.mem_req_valid  = req_valid;
    assign mem.mem_req_rw     = (state == StWrite);
    assign mem.mem_req_byteen = {(DATA_WIDTH/8){req_valid}};
    assign mem.mem_req_addr   = req_valid ? addr_q : '0;
    assign mem.mem_req_data   = (state == StWrite) ? wr_line : '0;
    assign mem.mem_req_tag    = alloc_valid_tag(state, full, alloc_idx);
    assign mem.mem_rsp_ready  = rsp_ready_q;

    function automatic logic [TAG_WIDTH-1:0] alloc_valid_tag(input tg_state_e st,
                                                             input logic is_full,
                                                             input logic [SLOT_W-1:0] idx);
        return ((st == StRead) && !is_full) ? TAG_WIDTH'(idx) : '0;
    endfunction

    // Tags are in range only when no bits above the slot index are set.
    assign rsp_idx   = mem.mem_rsp_tag[SLOT_W-1:0];
    assign rsp_fire  = mem.mem_rsp_valid && rsp_ready_q;
    assign rsp_hit   = rsp_fire && ((mem.mem_rsp_tag >> SLOT_W) == '0) && !free_map[rsp_idx];
    assign rsp_stray = rsp_fire && !rsp_hit;
    assign exp_line  = DATA_WIDTH'(gen_line(seed_q, 32'(slot_line_q[rsp_idx]), WORDS));
    assign rsp_bad   = rsp_hit && (mem.mem_rsp_data != exp_line);

    vx_tag_slot_alloc #(
        .NUM_SLOTS (MAX_OUTSTANDING),
        .SLOT_W    (SLOT_W)
    ) u_slot_alloc (
        .clk       (clk),
        .reset_n   (reset_n),
        .alloc     (alloc),
        .free      (rsp_hit),
        .free_idx  (rsp_idx),
        .alloc_idx (alloc_idx),
        .free_map  (free_map),
        .full      (full),
        .empty     (empty)
    );

    // Line index held per slot for response checking; validity lives in the bitmap.
    always_ff @(posedge clk) begin
        if (alloc) begin
            slot_line_q[alloc_idx] <= idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            base_q      <= '0;
            stride_q    <= '0;
            seed_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            rsp_ready_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            stray_rsp   <= 1'b0;
        end else begin
            rsp_ready_q <= 1'b1;
            done        <= 1'b0;
            if (rsp_stray) begin
                stray_rsp <= 1'b1;
            end
            if (rsp_bad && (err_count != '1)) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        base_q    <= base_addr;
                        stride_q  <= stride;
                        seed_q    <= seed;
                        num_q     <= num_lines;
                        idx_q     <= '0;
                        addr_q    <= base_addr;
                        busy      <= 1'b1;
                        err_count <= '0;
                        stray_rsp <= 1'b0;
                        if (num_lines == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StWrite;
                        end
                    end
                end
                StWrite, StRead: begin
                    if (req_fire) begin
                        if (last_line) begin
                            idx_q  <= '0;
                            addr_q <= base_q;
                            state  <= (state == StWrite) ? StRead : StDrain;
                        end else begin
                            idx_q  <= idx_q + CNT_WIDTH'(1);
                            addr_q <= addr_q + stride_q;
                        end
                    end
                end
                StDrain: begin
                    // empty already accounts for a slot freed this cycle.
                    if (empty) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef VX_TRAFFIC_GEN_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] stamp_q [MAX_OUTSTANDING];
    logic [31:0] lat;
    logic [32:0] sum_ext;
    logic [15:0] lat16;

    assign lat     = cyc_q - stamp_q[rsp_idx];
    assign sum_ext = {1'b0, perf_lat_sum} + {1'b0, lat};
    assign lat16   = (lat[31:16] != '0) ? 16'hFFFF : lat[15:0];

    always_ff @(posedge clk) begin
        if (alloc) begin
            stamp_q[alloc_idx] <= cyc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q        <= '0;
            perf_lat_sum <= '0;
            perf_lat_max <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if ((state == StIdle) && start) begin
                perf_lat_sum <= '0;
                perf_lat_max <= '0;
            end else if (rsp_hit) begin
                perf_lat_sum <= sum_ext[32] ? '1 : sum_ext[31:0];
                if (lat16 > perf_lat_max) begin
                    perf_lat_max <= lat16;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_traffic_gen.sv
// Scoreboard bench for vx_mem_traffic_gen: a memory model with configurable response
// latency / ordering answers reads; expected writes and read addresses are queued at
// start and popped as the DUT issues requests.
module tb_vx_mem_traffic_gen;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 26;
    localparam int unsigned TW = 8;
    localparam int unsigned MO = 16;
    localparam int unsigned CW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int unsigned   due;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_lines;
    logic [AW-1:0] stride;
    logic [31:0]   seed;
    logic          busy;
    logic          done;
    logic [CW-1:0] err_count;
    logic          stray_rsp;
`ifdef VX_TRAFFIC_GEN_PERF_EN
    logic [31:0]   perf_lat_sum;
    logic [15:0]   perf_lat_max;
`endif

    vx_mem_traffic_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) m ();

    vx_mem_traffic_gen #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .TAG_WIDTH       (TW),
        .MAX_OUTSTANDING (MO),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .stride    (stride),
        .seed      (seed),
        .mem       (m),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .stray_rsp (stray_rsp)
`ifdef VX_TRAFFIC_GEN_PERF_EN
        ,
        .perf_lat_sum (perf_lat_sum),
        .perf_lat_max (perf_lat_max)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model state and knobs
    logic [DW-1:0] mem [logic [AW-1:0]];
    wr_t           exp_wr [$];
    logic [AW-1:0] exp_rd [$];
    rsp_t          pipe [$];
    rsp_t          hold [$];
    logic [TW-1:0] inj [$];
    int unsigned   cyc = 0;
    int            rsp_mode = 1;      // 0: never answer, 1: in-order pipe, 2: hold + reverse
    int unsigned   lat = 1;
    int            hold_target = 0;
    bit            rdy_rand = 1'b0;
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    int            outstanding = 0;
    int            peak = 0;
    int            full_viol = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input logic [31:0] sd, input int unsigned i);
        logic [DW-1:0] p;
        for (int j = 0; j < DW / 32; j++) begin
            p[j*32 +: 32] = sd + i * (DW / 32) + j;
        end
        return p;
    endfunction

    // Memory responder: decides inputs for the next posedge and records the handshake
    // that edge will perform.
    initial begin
        rsp_t          r;
        int            mi;
        bit            pend;
        logic [AW-1:0] pend_addr;
        logic [DW-1:0] pend_data;
        logic          pend_rw;
        logic [DW-1:0] d;
        pend = 1'b0;
        m.mem_req_ready = 1'b0;
        m.mem_rsp_valid = 1'b0;
        m.mem_rsp_data  = '0;
        m.mem_rsp_tag   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (outstanding >= int'(MO) && m.mem_req_valid && !m.mem_req_rw) full_viol++;
            if (outstanding > peak) peak = outstanding;
            if (hold_target != 0 && hold.size() == hold_target) begin
                while (hold.size() > 0) begin
                    mi = 0;
                    for (int k = 1; k < hold.size(); k++) begin
                        if (hold[k].tag > hold[mi].tag) mi = k;
                    end
                    r = hold[mi];
                    r.due = cyc;
                    pipe.push_back(r);
                    hold.delete(mi);
                end
                hold_target = 0;
            end
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                r = pipe.pop_front();
                m.mem_rsp_valid = 1'b1;
                m.mem_rsp_data  = r.data;
                m.mem_rsp_tag   = r.tag;
                outstanding--;
            end else if (inj.size() > 0) begin
                m.mem_rsp_valid = 1'b1;
                m.mem_rsp_tag   = inj.pop_front();
                m.mem_rsp_data  = '0;
            end else begin
                m.mem_rsp_valid = 1'b0;
                m.mem_rsp_data  = '0;
                m.mem_rsp_tag   = '0;
            end
            m.mem_req_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
            if (pend) begin
                check("hold_valid", DW'(m.mem_req_valid), DW'(1'b1));
                check("hold_addr", DW'(m.mem_req_addr), DW'(pend_addr));
                check("hold_data", m.mem_req_data, pend_data);
                check("hold_rw", DW'(m.mem_req_rw), DW'(pend_rw));
                pend = 1'b0;
            end
            if (m.mem_req_valid && reset_n) begin
                if (!m.mem_req_ready) begin
                    pend      = 1'b1;
                    pend_addr = m.mem_req_addr;
                    pend_data = m.mem_req_data;
                    pend_rw   = m.mem_req_rw;
                end else if (m.mem_req_rw) begin
                    mem[m.mem_req_addr] = m.mem_req_data;
                    check("wr_byteen", DW'(m.mem_req_byteen), DW'({(DW/8){1'b1}}));
                    check("wr_tag", DW'(m.mem_req_tag), '0);
                    if (exp_wr.size() == 0) begin
                        check("unexpected_wr", DW'(1'b1), DW'(1'b0));
                    end else begin
                        check("wr_addr", DW'(m.mem_req_addr), DW'(exp_wr[0].addr));
                        check("wr_data", m.mem_req_data, exp_wr[0].data);
                        void'(exp_wr.pop_front());
                    end
                end else begin
                    if (exp_rd.size() == 0) begin
                        check("unexpected_rd", DW'(1'b1), DW'(1'b0));
                    end else begin
                        check("rd_addr", DW'(m.mem_req_addr), DW'(exp_rd.pop_front()));
                    end
                    d = mem.exists(m.mem_req_addr) ? mem[m.mem_req_addr] : '0;
                    if (corrupt_en && m.mem_req_addr == corrupt_addr) d[31:0] = ~d[31:0];
                    r.tag  = m.mem_req_tag;
                    r.data = d;
                    r.due  = cyc + lat;
                    outstanding++;
                    if (rsp_mode == 1) pipe.push_back(r);
                    else if (rsp_mode == 2) hold.push_back(r);
                end
            end
        end
    end

    task automatic run(input logic [AW-1:0] b, input int unsigned n, input logic [AW-1:0] s,
                       input logic [31:0] sd, input int exp_err, input string name);
        logic [AW-1:0] a;
        int            k;
        for (int unsigned i = 0; i < n; i++) begin
            a = b + AW'(i) * s;
            exp_wr.push_back('{addr: a, data: pattern(sd, i)});
            exp_rd.push_back(a);
        end
        @(negedge clk);
        base_addr = b;
        num_lines = CW'(n);
        stride    = s;
        seed      = sd;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check({name, "_done_next"}, DW'(done), DW'(1'b1));
            check({name, "_no_req"}, DW'(m.mem_req_valid), DW'(1'b0));
            @(negedge clk);
            check({name, "_done_1cyc"}, DW'(done), DW'(1'b0));
            check({name, "_idle"}, DW'(busy), DW'(1'b0));
            check({name, "_no_traffic"}, DW'(exp_wr.size()), '0);
            return;
        end
        check({name, "_first_req"}, DW'(m.mem_req_valid), DW'(1'b1));
        check({name, "_busy"}, DW'(busy), DW'(1'b1));
        k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, DW'(done), DW'(1'b1));
        check({name, "_err_count"}, DW'(err_count), DW'(exp_err));
        check({name, "_stray"}, DW'(stray_rsp), DW'(1'b0));
        check({name, "_wr_left"}, DW'(exp_wr.size()), '0);
        check({name, "_rd_left"}, DW'(exp_rd.size()), '0);
        check({name, "_outstanding"}, DW'(outstanding), '0);
        @(negedge clk);
        check({name, "_busy_after"}, DW'(busy), DW'(1'b0));
        check({name, "_done_pulse"}, DW'(done), DW'(1'b0));
        exp_wr.delete();
        exp_rd.delete();
    endtask

    initial begin
        int k;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_lines = '0;
        stride    = '0;
        seed      = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", DW'(m.mem_req_valid), DW'(1'b0));
        check("rst_busy", DW'(busy), DW'(1'b0));
        check("rst_done", DW'(done), DW'(1'b0));
        check("rst_err", DW'(err_count), '0);
        check("rst_stray", DW'(stray_rsp), DW'(1'b0));
        check("rst_rsp_ready", DW'(m.mem_rsp_ready), DW'(1'b0));
        check("rst_addr", DW'(m.mem_req_addr), '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rsp_ready_up", DW'(m.mem_rsp_ready), DW'(1'b1));

        // Stray response while idle
        inj.push_back(TW'(5));
        repeat (3) @(negedge clk);
        check("idle_stray", DW'(stray_rsp), DW'(1'b1));
        check("idle_stray_err", DW'(err_count), '0);
        check("idle_stray_busy", DW'(busy), DW'(1'b0));

        // Ideal memory; start also clears the sticky stray flag
        rsp_mode = 1; lat = 1;
        run(AW'('h100), 4, AW'(1), 32'h0, 0, "basic");

        // Line 2 returned corrupted, with random request backpressure
        corrupt_en = 1'b1; corrupt_addr = AW'('h102); rdy_rand = 1'b1;
        run(AW'('h100), 4, AW'(1), 32'h1234_5678, 1, "corrupt");
        corrupt_en = 1'b0; rdy_rand = 1'b0;

        // 20-cycle response pipe: slot table must fill and throttle reads
        lat = 20; peak = 0; full_viol = 0;
        run(AW'('h2000), 64, AW'(3), $urandom, 0, "pipe20");
        check("pipe20_peak", DW'(peak), DW'(MO));
        check("pipe20_full_hold", DW'(full_viol), '0);
        lat = 1;

        // Reverse tag order responses
        rsp_mode = 2; hold_target = 8;
        run(AW'('h40), 8, AW'(2), 32'hdead_beef, 0, "reverse");
        rsp_mode = 1;

        // Zero lines, then address wrap with backpressure
        run(AW'('h77), 0, AW'(1), 32'h1, 0, "zero");
        rdy_rand = 1'b1; lat = 3;
        run({AW{1'b1}}, 2, AW'(1), 32'hffff_fff0, 0, "wrap");
        rdy_rand = 1'b0; lat = 1;

        // Reset mid-READ with responses withheld; later response is stray
        rsp_mode = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            exp_wr.push_back('{addr: AW'(i), data: pattern(32'h55, i)});
            exp_rd.push_back(AW'(i));
        end
        @(negedge clk);
        base_addr = '0; num_lines = CW'(64); stride = AW'(1); seed = 32'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (outstanding < 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("midrst_reads_issued", DW'(outstanding >= 4), DW'(1'b1));
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", DW'(busy), DW'(1'b0));
        check("midrst_valid", DW'(m.mem_req_valid), DW'(1'b0));
        check("midrst_rsp_ready", DW'(m.mem_rsp_ready), DW'(1'b0));
        check("midrst_err", DW'(err_count), '0);
        exp_wr.delete(); exp_rd.delete(); pipe.delete(); hold.delete();
        outstanding = 0;
        rsp_mode = 1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        inj.push_back(TW'(0));
        repeat (4) @(negedge clk);
        check("midrst_stray", DW'(stray_rsp), DW'(1'b1));
        check("midrst_stray_err", DW'(err_count), '0);
        check("midrst_idle", DW'(busy), DW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
